// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequencing controller for the multicycle RV32 datapath.
// Define ILLEGAL_TRAP_EN to send unknown opcodes to a sticky TRAP state instead of retiring them as NOPs.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [1:0] ALU_flags,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALU_op,
    output logic [1:0] Result_src,
    output logic [2:0] ImmSrc,
    output logic       instr_done,
    output logic       illegal_instr
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JLINK, LUI, TRAP
    } state_t;

    typedef struct packed {
        logic       req;
        logic       mw;
        logic       adr;
        logic       rw;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] op;
        logic [1:0] res;
    } moore_t;

`ifdef ILLEGAL_TRAP_EN
    localparam state_t UNKNOWN_NEXT = TRAP;
`else
    localparam state_t UNKNOWN_NEXT = FETCH;
`endif

    state_t     state_q, state_d;
    moore_t     out_q;
    logic       taken;
    logic [2:0] imm_sel;

    // State-only outputs; anything a state leaves unspecified keeps its reset value.
    function automatic moore_t moore(input state_t s);
        moore_t m;
        m = '{req: 1'b0, mw: 1'b0, adr: 1'b0, rw: 1'b0, a: 2'b00, b: 2'b10, op: 3'b000, res: 2'b10};
        case (s)
            FETCH:    m.req = 1'b1;
            DECODE:   begin m.a = 2'b01; m.b = 2'b01; end
            MEMADR:   begin m.a = 2'b10; m.b = 2'b01; end
            MEMREAD:  begin m.req = 1'b1; m.adr = 1'b1; end
            MEMWB:    begin m.res = 2'b01; m.rw = 1'b1; end
            MEMWRITE: begin m.req = 1'b1; m.mw = 1'b1; m.adr = 1'b1; end
            EXECR:    begin m.a = 2'b10; m.b = 2'b00; m.op = 3'b010; end
            EXECI:    begin m.a = 2'b10; m.b = 2'b01; m.op = 3'b010; end
            ALUWB:    begin m.res = 2'b00; m.rw = 1'b1; end
            BRANCH:   begin m.a = 2'b10; m.b = 2'b00; m.op = 3'b001; m.res = 2'b00; end
            JAL:      begin m.a = 2'b01; m.res = 2'b00; end
            JALR:     begin m.a = 2'b10; m.b = 2'b01; end
            JLINK:    begin m.a = 2'b01; m.rw = 1'b1; end
            LUI:      begin m.a = 2'b11; m.b = 2'b01; end
            default:  ;
        endcase
        return m;
    endfunction

    assign taken = (funct3 == 3'b000 &&  ALU_flags[0]) ||
                   (funct3 == 3'b001 && !ALU_flags[0]) ||
                   (funct3 == 3'b100 &&  ALU_flags[1]) ||
                   (funct3 == 3'b101 && !ALU_flags[1]);

    assign imm_sel = (opcode == 7'b0100011) ? 3'b001 :
                     (opcode == 7'b1100011) ? 3'b010 :
                     (opcode == 7'b1101111) ? 3'b011 :
                     (opcode == 7'b0110111) ? 3'b100 : 3'b000;

    // Next-state selection; memory states hold until mem_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    7'b0000011, 7'b0100011: state_d = MEMADR;
                    7'b0110011: state_d = EXECR;
                    7'b0010011: state_d = EXECI;
                    7'b1100011: state_d = BRANCH;
                    7'b1101111: state_d = JAL;
                    7'b1100111: state_d = JALR;
                    7'b0110111: state_d = LUI;
                    default:    state_d = UNKNOWN_NEXT;
                endcase
            end
            MEMADR:   state_d = (opcode == 7'b0100011) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECR, EXECI, JAL, LUI: state_d = ALUWB;
            JALR:     state_d = JLINK;
            MEMWB, ALUWB, BRANCH, JLINK: state_d = FETCH;
            default:  state_d = state_q;
        endcase
    end

    // State register plus registered Moore outputs computed from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            out_q   <= moore(FETCH);
        end else begin
            state_q <= state_d;
            out_q   <= moore(state_d);
        end
    end

    // Reset overrides every output combinationally so enables drop without a clock edge.
    assign mem_req    = rst_n && out_q.req;
    assign MemWrite   = rst_n && out_q.mw;
    assign AdrSrc     = rst_n && out_q.adr;
    assign RegWrite   = rst_n && out_q.rw;
    assign ALUSrcA    = rst_n ? out_q.a   : 2'b00;
    assign ALUSrcB    = rst_n ? out_q.b   : 2'b10;
    assign ALU_op     = rst_n ? out_q.op  : 3'b000;
    assign Result_src = rst_n ? out_q.res : 2'b10;
    assign ImmSrc     = (rst_n && state_q != FETCH) ? imm_sel : 3'b000;
    assign IRWrite    = rst_n && state_q == FETCH && mem_ready;
    assign PCWrite    = rst_n && ((state_q == FETCH && mem_ready) || state_q == JAL ||
                                  state_q == JALR || (state_q == BRANCH && taken));
    assign instr_done = rst_n && (state_q == MEMWB || state_q == ALUWB || state_q == JLINK ||
                                  state_q == BRANCH || (state_q == MEMWRITE && mem_ready) ||
                                  (state_q == DECODE && state_d == FETCH));
`ifdef ILLEGAL_TRAP_EN
    assign illegal_instr = rst_n && state_q == TRAP;
`else
    assign illegal_instr = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm: directed instruction sequences checked cycle by cycle against a per-instruction cycle plan.
module tb_multicycle_control_fsm;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [1:0] ALU_flags;
    logic       mem_ready;
    logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, instr_done, illegal_instr;
    logic [1:0] ALUSrcA, ALUSrcB, Result_src;
    logic [2:0] ALU_op, ImmSrc;

    int          checks = 0;
    int          errors = 0;
    int          instr_n = 0;
    int          cyc = 0;
    logic        cur_valid = 1'b0;
    logic [19:0] cur_exp;
    logic [20:0] plan[$];
    logic [19:0] dut_vec;

    localparam logic [19:0] RESET_VEC = {6'b000000, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 1'b0, 1'b0};
    localparam logic [19:0] FETCH_IDLE = {6'b100000, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 1'b0, 1'b0};

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .ALU_flags(ALU_flags),
        .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALU_op(ALU_op), .Result_src(Result_src), .ImmSrc(ImmSrc),
        .instr_done(instr_done), .illegal_instr(illegal_instr)
    );

    assign dut_vec = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
                      ALU_op, Result_src, ImmSrc, instr_done, illegal_instr};

    always #5 clk = ~clk;

    // Per-cycle comparison against the planned outputs
    always @(negedge clk) begin
        if (cur_valid) begin
            checks++;
            if (dut_vec !== cur_exp) begin
                errors++;
                $display("FAIL cyc instr=%0d cyc=%0d got=%h exp=%h", instr_n, cyc, dut_vec, cur_exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic bit rr();
        return bit'($urandom_range(0, 1));
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
            7'b0110111: return 3'b100;
            default:    return 3'b000;
        endcase
    endfunction

    // c = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite}
    task automatic push(input bit rdy, input logic [5:0] c, input logic [1:0] a, input logic [1:0] b,
                        input logic [2:0] op, input logic [1:0] res, input logic [2:0] imm,
                        input bit done, input bit ill);
        plan.push_back({rdy, c, a, b, op, res, imm, done, ill});
    endtask

    // Expected cycle sequence of one instruction: fetch, decode, then the class-specific steps
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] fl,
                         input int fw, input int mw);
        logic [2:0] im;
        bit known, tk;
        im = imm_of(op);
        known = op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
        case (f3)
            3'b000:  tk = fl[0];
            3'b001:  tk = !fl[0];
            3'b100:  tk = fl[1];
            3'b101:  tk = !fl[1];
            default: tk = 1'b0;
        endcase
        plan.delete();
        for (int i = 0; i < fw; i++) push(0, 6'b100000, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 0, 0);
        push(1, 6'b100110, 2'b00, 2'b10, 3'b000, 2'b10, 3'b000, 0, 0);
`ifdef ILLEGAL_TRAP_EN
        push(rr(), 6'b000000, 2'b01, 2'b01, 3'b000, 2'b10, im, 0, 0);
`else
        push(rr(), 6'b000000, 2'b01, 2'b01, 3'b000, 2'b10, im, !known, 0);
`endif
        case (op)
            7'b0110011: push(rr(), 6'b000000, 2'b10, 2'b00, 3'b010, 2'b10, im, 0, 0);
            7'b0010011: push(rr(), 6'b000000, 2'b10, 2'b01, 3'b010, 2'b10, im, 0, 0);
            7'b0000011, 7'b0100011: push(rr(), 6'b000000, 2'b10, 2'b01, 3'b000, 2'b10, im, 0, 0);
            7'b1100011: push(rr(), {4'b0000, tk, 1'b0}, 2'b10, 2'b00, 3'b001, 2'b00, im, 1, 0);
            7'b1101111: push(rr(), 6'b000010, 2'b01, 2'b10, 3'b000, 2'b00, im, 0, 0);
            7'b1100111: begin
                push(rr(), 6'b000010, 2'b10, 2'b01, 3'b000, 2'b10, im, 0, 0);
                push(rr(), 6'b000001, 2'b01, 2'b10, 3'b000, 2'b10, im, 1, 0);
            end
            7'b0110111: push(rr(), 6'b000000, 2'b11, 2'b01, 3'b000, 2'b10, im, 0, 0);
            default: ;
        endcase
        if (op inside {7'b0110011, 7'b0010011, 7'b1101111, 7'b0110111})
            push(rr(), 6'b000001, 2'b00, 2'b10, 3'b000, 2'b00, im, 1, 0);
        if (op == 7'b0000011) begin
            for (int i = 0; i < mw; i++) push(0, 6'b101000, 2'b00, 2'b10, 3'b000, 2'b10, im, 0, 0);
            push(1, 6'b101000, 2'b00, 2'b10, 3'b000, 2'b10, im, 0, 0);
            push(rr(), 6'b000001, 2'b00, 2'b10, 3'b000, 2'b01, im, 1, 0);
        end
        if (op == 7'b0100011) begin
            for (int i = 0; i < mw; i++) push(0, 6'b111000, 2'b00, 2'b10, 3'b000, 2'b10, im, 0, 0);
            push(1, 6'b111000, 2'b00, 2'b10, 3'b000, 2'b10, im, 1, 0);
        end
`ifdef ILLEGAL_TRAP_EN
        if (!known)
            for (int i = 0; i < 5; i++) push(1, 6'b000000, 2'b00, 2'b10, 3'b000, 2'b10, im, 0, 1);
`endif
    endtask

    // Runs up to lim planned cycles of one instruction, driving inputs just after each rising edge
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] fl,
                       input int fw, input int mw, input int exp_len, input int lim);
        build(op, f3, fl, fw, mw);
        chk($sformatf("plan_len op=%b f3=%b", op, f3), plan.size(), exp_len);
        foreach (plan[i]) begin
            if (i < lim) begin
                @(posedge clk);
                #1;
                opcode    = op;
                funct3    = f3;
                ALU_flags = fl;
                mem_ready = plan[i][20];
                cur_exp   = plan[i][19:0];
                cyc       = i;
                cur_valid = 1'b1;
            end
        end
        instr_n++;
    endtask

    initial begin
        logic [2:0] bf3[5];
        bf3 = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b010};
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 7'b0; funct3 = 3'b0; ALU_flags = 2'b0;
        #1;
        chk("reset_vec_t1", dut_vec, RESET_VEC);
        @(posedge clk); #1;
        chk("reset_vec_edge", dut_vec, RESET_VEC);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("first_fetch", dut_vec, FETCH_IDLE);

        run(7'b0110011, 3'b000, 2'b00, 0, 0, 4, 1000);
        run(7'b0010011, 3'b000, 2'b00, 0, 0, 4, 1000);
        run(7'b0000011, 3'b010, 2'b00, 0, 2, 7, 1000);
        run(7'b0000011, 3'b010, 2'b00, 0, 0, 5, 1000);
        run(7'b0100011, 3'b010, 2'b00, 1, 1, 6, 1000);
        for (int i = 0; i < 5; i++) begin
            run(7'b1100011, bf3[i], 2'b01, 0, 0, 3, 1000);
            run(7'b1100011, bf3[i], 2'b10, 0, 0, 3, 1000);
        end
        run(7'b1101111, 3'b000, 2'b00, 0, 0, 4, 1000);
        run(7'b1100111, 3'b000, 2'b00, 0, 0, 4, 1000);
        run(7'b0110111, 3'b000, 2'b00, 0, 0, 4, 1000);

        run(7'b0100011, 3'b010, 2'b00, 0, 3, 7, 4);
        @(negedge clk); #1;
        cur_valid = 1'b0;
        chk("memwrite_before_reset", {mem_req, MemWrite}, 2'b11);
        rst_n = 1'b0;
        #1;
        chk("async_reset_drop", dut_vec, RESET_VEC);
        @(posedge clk); #1;
        chk("reset_hold", dut_vec, RESET_VEC);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("fetch_after_release", dut_vec, FETCH_IDLE);

        run(7'b0110011, 3'b000, 2'b00, 2, 0, 6, 1000);
`ifdef ILLEGAL_TRAP_EN
        run(7'b1111111, 3'b000, 2'b00, 0, 0, 7, 1000);
`else
        run(7'b1111111, 3'b000, 2'b00, 0, 0, 2, 1000);
        run(7'b0110011, 3'b000, 2'b00, 0, 0, 4, 1000);
`endif
        @(posedge clk); #1;
        cur_valid = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
